// File: rtl/fifo_msg_pkg.sv
// fifo_msg_pkg: state encoding and default sizing shared by the message receiver
//   IDLE/HREQ/HCAP : wait for, request and capture a header word
//   PWAIT/PREQ/PCAP: wait for room, request and capture one payload word
package fifo_msg_pkg;
    localparam int LEN_W_DEF   = 16;
    localparam int MAX_LEN_DEF = 255;
    typedef enum logic [2:0] {
        IDLE,
        HREQ,
        HCAP,
        PWAIT,
        PREQ,
        PCAP
    } state_t;
endpackage

// File: rtl/fifo_msg_rx.sv
// fifo_msg_rx: drains an upstream FIFO as header-framed messages onto a valid/ready stream
//   clk, resetn          : clock, asynchronous active-low reset
//   fifo_empty/fifo_rd   : upstream FIFO status and one-cycle read pulse
//   fifo_data            : FIFO word, valid the cycle after fifo_rd was high
//   out_valid/out_ready  : payload handshake; out_data/out_sop/out_eop form the beat
//   out_len              : length of the current message, held until the next header
//   err_len              : one-cycle pulse on a rejected header (length 0 or > MAX_LEN)
//   msg_count            : completed messages, wrapping 16-bit count
module fifo_msg_rx
    import fifo_msg_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sop,
    output logic             out_eop,
    output logic [LEN_W-1:0] out_len,
    output logic             err_len,
    output logic [15:0]      msg_count
);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] hdr_len;
    logic             hdr_ok;
    logic             accept;

    assign hdr_len = fifo_data[LEN_W-1:0];
    assign hdr_ok  = (hdr_len != '0) && (hdr_len <= MAX_L);
    assign accept  = out_valid && out_ready;

    // fifo_rd is registered on entry to HREQ/PREQ so it is high exactly for
    // that one state; every request state is followed by a capture state,
    // which keeps the read strobe from ever lasting two cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            fifo_rd   <= 1'b0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            err_len   <= 1'b0;
            out_data  <= '0;
            out_len   <= '0;
            remaining <= '0;
            msg_count <= '0;
        end else begin
            fifo_rd <= 1'b0;
            err_len <= 1'b0;
            if (accept)
                out_valid <= 1'b0;
            if (accept && out_eop)
                msg_count <= msg_count + 16'd1;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state   <= HREQ;
                        fifo_rd <= 1'b1;
                    end
                end
                HREQ: state <= HCAP;
                HCAP: begin
                    if (hdr_ok) begin
                        remaining <= hdr_len;
                        out_len   <= hdr_len;
                        state     <= PWAIT;
                    end else begin
                        err_len <= 1'b1;
                        state   <= IDLE;
                    end
                end
                // Only fetch once the output register is free or being freed
                // this cycle; the fetched word lands two cycles later.
                PWAIT: begin
                    if (!fifo_empty && (!out_valid || out_ready)) begin
                        state   <= PREQ;
                        fifo_rd <= 1'b1;
                    end
                end
                PREQ: state <= PCAP;
                PCAP: begin
                    out_data  <= fifo_data;
                    out_valid <= 1'b1;
                    out_sop   <= remaining == out_len;
                    out_eop   <= remaining == ONE;
                    remaining <= remaining - ONE;
                    state     <= (remaining == ONE) ? IDLE : PWAIT;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_msg_rx.sv
// tb_fifo_msg_rx: directed checks of fifo_msg_rx against a behavioural FIFO
module tb_fifo_msg_rx;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [31:0] fifo_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic [15:0] out_len;
    logic        err_len;
    logic [15:0] msg_count;

    int passed = 0;
    int total = 0;

    logic [31:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;

    logic [31:0] bd [0:127];
    logic        bs [0:127];
    logic        be [0:127];
    int nb = 0;
    int err_cnt = 0;
    logic prev_rd = 1'b0;
    logic adj_rd = 1'b0;

    fifo_msg_rx dut (
        .clk(clk),
        .resetn(resetn),
        .fifo_empty(fifo_empty),
        .fifo_rd(fifo_rd),
        .fifo_data(fifo_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_sop(out_sop),
        .out_eop(out_eop),
        .out_len(out_len),
        .err_len(err_len),
        .msg_count(msg_count)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_data <= mem[rd_ptr[7:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    always @(posedge clk) begin
        if (out_valid && out_ready && nb < 128) begin
            bd[nb] <= out_data;
            bs[nb] <= out_sop;
            be[nb] <= out_eop;
            nb <= nb + 1;
        end
        if (err_len)
            err_cnt <= err_cnt + 1;
        if (fifo_rd && prev_rd)
            adj_rd <= 1'b1;
        prev_rd <= fifo_rd;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[7:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_beats(input int target, input string tag);
        int k = 0;
        while (nb < target && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk(tag, 64'(nb), 64'(target));
    endtask

    task automatic chk_beat(input int i, input logic [31:0] d, input logic s, input logic e, input string tag);
        chk({tag, "_data"}, 64'(bd[i]), 64'(d));
        chk({tag, "_sop"}, 64'(bs[i]), 64'(s));
        chk({tag, "_eop"}, 64'(be[i]), 64'(e));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_sop"}, 64'(out_sop), 64'd0);
        chk({tag, "_eop"}, 64'(out_eop), 64'd0);
        chk({tag, "_data"}, 64'(out_data), 64'd0);
        chk({tag, "_len"}, 64'(out_len), 64'd0);
        chk({tag, "_cnt"}, 64'(msg_count), 64'd0);
        chk({tag, "_rd"}, 64'(fifo_rd), 64'd0);
        chk({tag, "_err"}, 64'(err_len), 64'd0);
    endtask

    initial begin
        int base;
        int rbase;
        int k;
        #1;
        chk_zero("reset");
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // basic length-3 message
        base = nb;
        push(32'd3); push(32'hA1); push(32'hA2); push(32'hA3);
        wait_beats(base + 3, "m1_beats");
        chk_beat(base, 32'hA1, 1'b1, 1'b0, "m1_b0");
        chk_beat(base + 1, 32'hA2, 1'b0, 1'b0, "m1_b1");
        chk_beat(base + 2, 32'hA3, 1'b0, 1'b1, "m1_b2");
        chk("m1_len", 64'(out_len), 64'd3);
        chk("m1_cnt", 64'(msg_count), 64'd1);
        chk("m1_adj_rd", 64'(adj_rd), 64'd0);

        // rejected headers: length 0 and length 256
        base = nb;
        push(32'd0); push(32'h100);
        k = 0;
        while (err_cnt < 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        chk("err_pulses", 64'(err_cnt), 64'd2);
        chk("err_nobeat", 64'(nb), 64'(base));
        chk("err_novalid", 64'(out_valid), 64'd0);
        chk("err_len_kept", 64'(out_len), 64'd3);
        push(32'h5A5A_0001); push(32'hC1);
        wait_beats(base + 1, "hdr_beats");
        chk_beat(base, 32'hC1, 1'b1, 1'b1, "hdr_b0");
        chk("hdr_len", 64'(out_len), 64'd1);
        chk("hdr_cnt", 64'(msg_count), 64'd2);

        // backpressure holds the first beat and blocks further reads
        base = nb;
        out_ready = 1'b0;
        rbase = rd_ptr;
        push(32'd2); push(32'hB1); push(32'hB2);
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_data", 64'(out_data), 64'hB1);
            chk("bp_sop", 64'(out_sop), 64'd1);
            chk("bp_rd", 64'(rd_ptr), 64'(rbase + 2));
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_beats(base + 2, "bp_beats");
        chk_beat(base, 32'hB1, 1'b1, 1'b0, "bp_b0");
        chk_beat(base + 1, 32'hB2, 1'b0, 1'b1, "bp_b1");
        chk("bp_cnt", 64'(msg_count), 64'd3);

        // FIFO drained mid-message: stall, then finish
        base = nb;
        push(32'd4); push(32'hD1); push(32'hD2);
        wait_beats(base + 2, "st_first");
        repeat (10) @(negedge clk);
        chk("st_stall", 64'(nb), 64'(base + 2));
        chk("st_cnt_hold", 64'(msg_count), 64'd3);
        push(32'hD3); push(32'hD4);
        wait_beats(base + 4, "st_beats");
        chk_beat(base + 2, 32'hD3, 1'b0, 1'b0, "st_b2");
        chk_beat(base + 3, 32'hD4, 1'b0, 1'b1, "st_b3");
        chk("st_len", 64'(out_len), 64'd4);
        chk("st_cnt", 64'(msg_count), 64'd4);

        // reset mid-message abandons it
        base = nb;
        push(32'd3); push(32'hE1);
        wait_beats(base + 1, "rst_first");
        resetn = 1'b0;
        #1;
        chk_zero("rst_mid");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        base = nb;
        push(32'd1); push(32'hF1);
        wait_beats(base + 1, "rst_beats");
        chk_beat(base, 32'hF1, 1'b1, 1'b1, "rst_b0");
        chk("rst_len", 64'(out_len), 64'd1);
        chk("rst_cnt", 64'(msg_count), 64'd1);

        // counter wrap, starting just below the top
        force dut.msg_count = 16'hFFFE;
        @(negedge clk);
        release dut.msg_count;
        @(negedge clk);
        base = nb;
        push(32'd1); push(32'h11);
        wait_beats(base + 1, "wrap_first");
        chk("wrap_ffff", 64'(msg_count), 64'hFFFF);
        push(32'd1); push(32'h22);
        wait_beats(base + 2, "wrap_second");
        chk("wrap_zero", 64'(msg_count), 64'd0);
        chk("adj_rd_all", 64'(adj_rd), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
